// File: rtl/psram_pkg.sv
// Shared types and helpers for the PSRAM DDR write data path.
package psram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAT,
    ST_DATA,
    ST_TAIL
  } state_e;

  // Clocks needed to send one write word as DDR beat pairs.
  function automatic int unsigned beats(int unsigned word_w, int unsigned dq_w);
    return word_w / (2 * dq_w);
  endfunction

endpackage

// File: rtl/psram_word_shifter.sv
// Holds the word being transmitted and presents the beat pair for the next clock.
module psram_word_shifter
  import psram_pkg::*;
#(
  parameter int unsigned DQ_W   = 8,
  parameter int unsigned WORD_W = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     load_i,
  input  logic                     adv_i,
  input  logic [WORD_W-1:0]        wdata_i,
  input  logic [WORD_W/DQ_W-1:0]   wmask_i,
  output logic [DQ_W-1:0]          nxt_d0_o,
  output logic [DQ_W-1:0]          nxt_d1_o,
  output logic                     nxt_m0_o,
  output logic                     nxt_m1_o,
  output logic                     last_beat_o,
  output logic                     last_nxt_o
);

  localparam int unsigned Beats = beats(WORD_W, DQ_W);
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned MaskW = WORD_W / DQ_W;

  logic [WORD_W-1:0] word_q, word_d, word_sh;
  logic [MaskW-1:0]  mask_q, mask_d, mask_sh;
  logic [BeatW-1:0]  beat_q, beat_d;
  int unsigned       sh_bits, sh_lanes;

  // Next word/beat selection and the pair that beat_d will put on the wire.
  always_comb begin
    word_d = word_q;
    mask_d = mask_q;
    beat_d = beat_q;
    if (load_i) begin
      word_d = wdata_i;
      mask_d = wmask_i;
      beat_d = '0;
    end else if (adv_i) begin
      beat_d = beat_q + 1'b1;
    end
    sh_lanes    = 32'(beat_d) * 2;
    sh_bits     = sh_lanes * DQ_W;
    word_sh     = word_d << sh_bits;
    mask_sh     = mask_d << sh_lanes;
    nxt_d0_o    = word_sh[WORD_W-1 -: DQ_W];
    nxt_d1_o    = word_sh[WORD_W-DQ_W-1 -: DQ_W];
    nxt_m0_o    = mask_sh[MaskW-1];
    nxt_m1_o    = mask_sh[MaskW-2];
    last_beat_o = (beat_q == BeatW'(Beats - 1));
    last_nxt_o  = (beat_d == BeatW'(Beats - 1));
  end

  // Word, mask and beat index storage.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      word_q <= '0;
      mask_q <= '0;
      beat_q <= '0;
    end else begin
      word_q <= word_d;
      mask_q <= mask_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/psram_dq_serializer.sv
// PSRAM DDR transmit path: burst sequencing and registered beat pairs for the ODDRs.
module psram_dq_serializer
  import psram_pkg::*;
#(
  parameter int unsigned DQ_W   = 8,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned LAT_W  = 5,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LAT_W-1:0]       latency,
  input  logic [LEN_W-1:0]       burst_len,
  input  logic [WORD_W-1:0]      wdata,
  input  logic [WORD_W/DQ_W-1:0] wmask,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [DQ_W-1:0]        oddr_d0,
  output logic [DQ_W-1:0]        oddr_d1,
  output logic                   rwds_d0,
  output logic                   rwds_d1,
  output logic                   dq_oe,
  output logic                   busy,
  output logic                   done,
  output logic                   underrun
);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic             fill_q, fill_d;
  logic             underrun_q, underrun_d;
  logic             done_q, done_d;
  logic             oe_q, oe_d;
  logic             wready_q, wready_d;
  logic             busy_q, busy_d;
  logic [DQ_W-1:0]  d0_q, d0_d, d1_q, d1_d;
  logic             r0_q, r0_d, r1_q, r1_d;

  logic             accept, need_word, load, adv;
  logic [DQ_W-1:0]  sh_d0, sh_d1;
  logic             sh_m0, sh_m1, last_beat, last_nxt;

  assign accept = wvalid & wready_q;

  psram_word_shifter #(
    .DQ_W  (DQ_W),
    .WORD_W(WORD_W)
  ) u_shifter (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (load),
    .adv_i      (adv),
    .wdata_i    (wdata),
    .wmask_i    (wmask),
    .nxt_d0_o   (sh_d0),
    .nxt_d1_o   (sh_d1),
    .nxt_m0_o   (sh_m0),
    .nxt_m1_o   (sh_m1),
    .last_beat_o(last_beat),
    .last_nxt_o (last_nxt)
  );

  // Burst sequencing; every output is computed one clock ahead and registered.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    word_cnt_d = word_cnt_q;
    fill_d     = fill_q;
    underrun_d = underrun_q;
    done_d     = 1'b0;
    need_word  = 1'b0;
    load       = 1'b0;
    adv        = 1'b0;
    d0_d       = '0;
    d1_d       = '0;
    r0_d       = 1'b0;
    r1_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          underrun_d = 1'b0;
          if (burst_len != '0) begin
            state_d    = ST_LAT;
            lat_cnt_d  = (latency == '0) ? LAT_W'(1) : latency;
            word_cnt_d = burst_len;
            fill_d     = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_LAT: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q == LAT_W'(1)) begin
          state_d   = ST_DATA;
          need_word = 1'b1;
        end
      end
      ST_DATA: begin
        if (fill_q) begin
          need_word = 1'b1;
        end else if (!last_beat) begin
          adv = 1'b1;
        end else begin
          word_cnt_d = word_cnt_q - 1'b1;
          if (word_cnt_q == LEN_W'(1)) begin
            state_d = ST_TAIL;
          end else begin
            need_word = 1'b1;
          end
        end
      end
      ST_TAIL: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A missing word becomes a masked filler beat, retried every clock.
    if (need_word) begin
      if (accept) begin
        load   = 1'b1;
        fill_d = 1'b0;
      end else begin
        fill_d     = 1'b1;
        underrun_d = 1'b1;
      end
    end

    if (load || adv) begin
      d0_d = sh_d0;
      d1_d = sh_d1;
      r0_d = sh_m0;
      r1_d = sh_m1;
    end else if (state_d == ST_DATA) begin
      r0_d = 1'b1;
      r1_d = 1'b1;
    end

    oe_d     = (state_d == ST_DATA) || (state_d == ST_TAIL);
    busy_d   = (state_d != ST_IDLE);
    wready_d = ((state_d == ST_LAT) && (lat_cnt_d == LAT_W'(1))) ||
               ((state_d == ST_DATA) &&
                (fill_d || (last_nxt && (word_cnt_d > LEN_W'(1)))));
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lat_cnt_q  <= '0;
      word_cnt_q <= '0;
      fill_q     <= 1'b0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
      oe_q       <= 1'b0;
      wready_q   <= 1'b0;
      busy_q     <= 1'b0;
      d0_q       <= '0;
      d1_q       <= '0;
      r0_q       <= 1'b0;
      r1_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      word_cnt_q <= word_cnt_d;
      fill_q     <= fill_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
      oe_q       <= oe_d;
      wready_q   <= wready_d;
      busy_q     <= busy_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      r0_q       <= r0_d;
      r1_q       <= r1_d;
    end
  end

  assign wready   = wready_q;
  assign oddr_d0  = d0_q;
  assign oddr_d1  = d1_q;
  assign rwds_d0  = r0_q;
  assign rwds_d1  = r1_q;
  assign dq_oe    = oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_psram_dq_serializer.sv
// Directed bench for psram_dq_serializer: per-cycle output traces against hand-built tables.
module tb_psram_dq_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  latency = '0;
  logic [7:0]  burst_len = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [7:0]  oddr_d0, oddr_d1;
  logic        rwds_d0, rwds_d1, dq_oe, busy, done, underrun;

  psram_dq_serializer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .latency  (latency),
    .burst_len(burst_len),
    .wdata    (wdata),
    .wmask    (wmask),
    .wvalid   (wvalid),
    .wready   (wready),
    .oddr_d0  (oddr_d0),
    .oddr_d1  (oddr_d1),
    .rwds_d0  (rwds_d0),
    .rwds_d1  (rwds_d1),
    .dq_oe    (dq_oe),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       oe;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
    logic       done;
    logic       busy;
    logic       wready;
    logic       ur;
  } obs_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  m;
  } wrd_t;

  obs_t tr[$];
  wrd_t wq[$];
  int   widx = 0;
  int   gap_idx = -1;
  int   gap_left = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  function automatic obs_t sample();
    obs_t o;
    o.oe = dq_oe;   o.d0 = oddr_d0; o.d1 = oddr_d1;
    o.r0 = rwds_d0; o.r1 = rwds_d1; o.done = done;
    o.busy = busy;  o.wready = wready; o.ur = underrun;
    return o;
  endfunction

  function automatic obs_t e(logic oe, logic [7:0] d0, logic [7:0] d1, logic [1:0] r,
                             logic dn, logic by, logic wr, logic ur);
    obs_t o;
    o.oe = oe; o.d0 = d0; o.d1 = d1; o.r0 = r[1]; o.r1 = r[0];
    o.done = dn; o.busy = by; o.wready = wr; o.ur = ur;
    return o;
  endfunction

  // Word source: presents queued words in order, holding off for gap_left offered slots.
  task automatic drive_w();
    if (widx < wq.size() && !(widx == gap_idx && gap_left > 0)) begin
      wvalid = 1'b1;
      wdata  = wq[widx].d;
      wmask  = wq[widx].m;
    end else begin
      wvalid = 1'b0;
      wdata  = '0;
      wmask  = '0;
    end
  endtask

  task automatic tick();
    logic acc;
    acc = wvalid && wready;
    if (wready && !wvalid && widx == gap_idx && gap_left > 0) gap_left--;
    @(posedge clk);
    #1;
    if (acc) widx++;
    tr.push_back(sample());
    start = 1'b0;
    drive_w();
  endtask

  task automatic begin_burst(input logic [4:0] lat, input logic [7:0] len);
    latency   = lat;
    burst_len = len;
    start     = 1'b1;
    widx      = 0;
    drive_w();
  endtask

  task automatic test_reset();
    obs_t ex[$];
    tr.delete();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) ex.push_back(e(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < ex.size(); i++) begin
      chk_cnt++;
      if (tr[i] !== ex[i])
        $display("FAIL reset cycle %0d: observed %h required %h", i, tr[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic_burst();
    obs_t ex[$];
    tr.delete();
    wq = '{'{32'h1122_3344, 4'b0000}, '{32'h5566_7788, 4'b0000}};
    begin_burst(5'd3, 8'd2);
    for (int i = 0; i < 10; i++) tick();
    ex = '{e(0, 0, 0, 0, 0, 1, 0, 0), e(0, 0, 0, 0, 0, 1, 0, 0),
           e(0, 0, 0, 0, 0, 1, 1, 0), e(1, 8'h11, 8'h22, 0, 0, 1, 0, 0),
           e(1, 8'h33, 8'h44, 0, 0, 1, 1, 0), e(1, 8'h55, 8'h66, 0, 0, 1, 0, 0),
           e(1, 8'h77, 8'h88, 0, 0, 1, 0, 0), e(1, 0, 0, 0, 0, 1, 0, 0),
           e(0, 0, 0, 0, 1, 0, 0, 0), e(0, 0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < ex.size(); i++) begin
      chk_cnt++;
      if (tr[i] !== ex[i])
        $display("FAIL basic_burst cycle %0d: observed %h required %h", i, tr[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mask();
    obs_t ex[$];
    tr.delete();
    wq = '{'{32'hA5A5_5A5A, 4'b0100}};
    begin_burst(5'd1, 8'd1);
    for (int i = 0; i < 6; i++) tick();
    ex = '{e(0, 0, 0, 0, 0, 1, 1, 0), e(1, 8'hA5, 8'hA5, 2'b01, 0, 1, 0, 0),
           e(1, 8'h5A, 8'h5A, 2'b00, 0, 1, 0, 0), e(1, 0, 0, 0, 0, 1, 0, 0),
           e(0, 0, 0, 0, 1, 0, 0, 0), e(0, 0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < ex.size(); i++) begin
      chk_cnt++;
      if (tr[i] !== ex[i])
        $display("FAIL mask cycle %0d: observed %h required %h", i, tr[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_underrun();
    obs_t ex[$];
    tr.delete();
    wq = '{'{32'h0102_0304, 4'b0000}, '{32'h0506_0708, 4'b0000},
           '{32'h090A_0B0C, 4'b0000}};
    gap_idx  = 1;
    gap_left = 2;
    begin_burst(5'd2, 8'd3);
    for (int i = 0; i < 13; i++) tick();
    gap_idx = -1;
    ex = '{e(0, 0, 0, 0, 0, 1, 0, 0), e(0, 0, 0, 0, 0, 1, 1, 0),
           e(1, 8'h01, 8'h02, 0, 0, 1, 0, 0), e(1, 8'h03, 8'h04, 0, 0, 1, 1, 0),
           e(1, 0, 0, 2'b11, 0, 1, 1, 1), e(1, 0, 0, 2'b11, 0, 1, 1, 1),
           e(1, 8'h05, 8'h06, 0, 0, 1, 0, 1), e(1, 8'h07, 8'h08, 0, 0, 1, 1, 1),
           e(1, 8'h09, 8'h0A, 0, 0, 1, 0, 1), e(1, 8'h0B, 8'h0C, 0, 0, 1, 0, 1),
           e(1, 0, 0, 0, 0, 1, 0, 1), e(0, 0, 0, 0, 1, 0, 0, 1),
           e(0, 0, 0, 0, 0, 0, 0, 1)};
    for (int i = 0; i < ex.size(); i++) begin
      chk_cnt++;
      if (tr[i] !== ex[i])
        $display("FAIL underrun cycle %0d: observed %h required %h", i, tr[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_len();
    obs_t ex[$];
    tr.delete();
    wq.delete();
    begin_burst(5'd3, 8'd0);
    for (int i = 0; i < 3; i++) tick();
    ex = '{e(0, 0, 0, 0, 1, 0, 0, 0), e(0, 0, 0, 0, 0, 0, 0, 0), e(0, 0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < ex.size(); i++) begin
      chk_cnt++;
      if (tr[i] !== ex[i])
        $display("FAIL zero_len cycle %0d: observed %h required %h", i, tr[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_ignored();
    obs_t ex[$];
    tr.delete();
    wq = '{'{32'hDEAD_BEEF, 4'b1001}, '{32'hCAFE_F00D, 4'b0110}};
    begin_burst(5'd1, 8'd2);
    tick();
    tick();
    latency   = 5'd5;
    burst_len = 8'd9;
    start     = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    ex = '{e(0, 0, 0, 0, 0, 1, 1, 0), e(1, 8'hDE, 8'hAD, 2'b10, 0, 1, 0, 0),
           e(1, 8'hBE, 8'hEF, 2'b01, 0, 1, 1, 0), e(1, 8'hCA, 8'hFE, 2'b01, 0, 1, 0, 0),
           e(1, 8'hF0, 8'h0D, 2'b10, 0, 1, 0, 0), e(1, 0, 0, 0, 0, 1, 0, 0),
           e(0, 0, 0, 0, 1, 0, 0, 0), e(0, 0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < ex.size(); i++) begin
      chk_cnt++;
      if (tr[i] !== ex[i])
        $display("FAIL start_ignored cycle %0d: observed %h required %h", i, tr[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_burst();
    obs_t ex[$];
    tr.delete();
    wq = '{'{32'hA1B2_C3D4, 4'b0000}, '{32'hE5F6_0718, 4'b0000}};
    begin_burst(5'd1, 8'd2);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    wq = '{'{32'h1357_9BDF, 4'b1000}};
    begin_burst(5'd2, 8'd1);
    for (int i = 0; i < 6; i++) tick();
    ex = '{e(0, 0, 0, 0, 0, 1, 1, 0), e(1, 8'hA1, 8'hB2, 0, 0, 1, 0, 0),
           e(1, 8'hC3, 8'hD4, 0, 0, 1, 1, 0), e(0, 0, 0, 0, 0, 0, 0, 0),
           e(0, 0, 0, 0, 0, 0, 0, 0), e(0, 0, 0, 0, 0, 1, 0, 0),
           e(0, 0, 0, 0, 0, 1, 1, 0), e(1, 8'h13, 8'h57, 2'b10, 0, 1, 0, 0),
           e(1, 8'h9B, 8'hDF, 0, 0, 1, 0, 0), e(1, 0, 0, 0, 0, 1, 0, 0),
           e(0, 0, 0, 0, 1, 0, 0, 0)};
    for (int i = 0; i < ex.size(); i++) begin
      chk_cnt++;
      if (tr[i] !== ex[i])
        $display("FAIL reset_mid_burst cycle %0d: observed %h required %h", i, tr[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_mask();
    test_underrun();
    test_zero_len();
    test_start_ignored();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
